chunked_cp_adder: RTL and testbench

- Parametrised, multi-cycle carry-propagate adder/subtractor and the successor to the fixed 3-bit combinational ripple adder.
- Each cycle it adds one CHUNK-bit slice with a combinational ripple, then registers the carry between slices.
- Adds add/subtract mode, signed-overflow detection and a start/busy/done handshake.
- Used in datapaths where a full-width ripple does not meet timing.

---
 rtl/chunked_cp_adder.sv | 167 ++++++++++++++++
 tb/tb_chunked_cp_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_cp_adder.sv
// chunked_cp_adder: multi-cycle carry-propagate adder/subtractor.
// Adds one CHUNK-bit slice per cycle with a combinational ripple and
// registers the carry between slices. Subtract computes a - b - cin.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only in IDLE
//   sub    0 = add, 1 = subtract (sampled with start)
//   a, b   WIDTH-bit operands (sampled with start)
//   cin    carry-in (add) / borrow-in (sub) (sampled with start)
//   busy   high while slices are being processed
//   done   one-cycle pulse when sum/co/ovf are updated
//   sum    WIDTH-bit result, held until the next completion
//   co     raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf    two's-complement signed overflow
module chunked_cp_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject parameter sets that cannot be sliced evenly.
    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_cp_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             carry_q, carry_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] work_q, work_n;
    logic [WIDTH-1:0] sum_n;
    logic             co_n, ovf_n, busy_n, done_n;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic [WIDTH-1:0] merged;
    logic             c_rip, c_msb;
    logic             last_slice;

    // Ripple the current slice; c_msb is the carry into the slice's top bit.
    always_comb begin
        sl_a   = '0;
        sl_b   = '0;
        sl_s   = '0;
        c_rip  = carry_q;
        c_msb  = carry_q;
        merged = work_q;
        for (int j = 0; j < int'(NCH); j++) begin
            if (cnt_q == CW'(j)) begin
                sl_a = a_q[j*CHUNK +: CHUNK];
                sl_b = b_q[j*CHUNK +: CHUNK];
            end
        end
        for (int i = 0; i < CHUNK; i++) begin
            c_msb   = c_rip;
            sl_s[i] = sl_a[i] ^ sl_b[i] ^ c_rip;
            c_rip   = (sl_a[i] & sl_b[i]) | (c_rip & (sl_a[i] ^ sl_b[i]));
        end
        for (int j = 0; j < int'(NCH); j++) begin
            if (cnt_q == CW'(j)) begin
                merged[j*CHUNK +: CHUNK] = sl_s;
            end
        end
    end

    assign last_slice = (cnt_q == CW'(NCH - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        carry_n = carry_q;
        a_n     = a_q;
        b_n     = b_q;
        work_n  = work_q;
        sum_n   = sum;
        co_n    = co;
        ovf_n   = ovf;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = sub ? ~b : b;
                    carry_n = sub ? ~cin : cin;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                work_n  = merged;
                carry_n = c_rip;
                if (last_slice) begin
                    cnt_n   = '0;
                    state_n = DONE;
                    sum_n   = merged;
                    co_n    = c_rip;
                    ovf_n   = c_msb ^ c_rip;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum     <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            carry_q <= carry_n;
            a_q     <= a_n;
            b_q     <= b_n;
            work_q  <= work_n;
            sum     <= sum_n;
            co      <= co_n;
            ovf     <= ovf_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_chunked_cp_adder.sv
// Directed bench for chunked_cp_adder in three configurations:
// d=0: WIDTH=3 CHUNK=1, d=1: WIDTH=8 CHUNK=2, d=2: WIDTH=8 CHUNK=8.
module tb_chunked_cp_adder;

    logic       clk;
    logic       rst;
    logic [2:0] st, sb, ci;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [2:0] bz, dn, cov, ovv;
    logic [2:0] sum0;
    logic [7:0] sum1, sum2;
    logic [7:0] prev [3];

    int n_checks;
    int n_fail;

    chunked_cp_adder #(.WIDTH(3), .CHUNK(1)) u_w3 (
        .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]),
        .a(av[0][2:0]), .b(bv[0][2:0]), .cin(ci[0]),
        .busy(bz[0]), .done(dn[0]), .sum(sum0), .co(cov[0]), .ovf(ovv[0])
    );

    chunked_cp_adder #(.WIDTH(8), .CHUNK(2)) u_w8 (
        .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]),
        .a(av[1]), .b(bv[1]), .cin(ci[1]),
        .busy(bz[1]), .done(dn[1]), .sum(sum1), .co(cov[1]), .ovf(ovv[1])
    );

    chunked_cp_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]),
        .a(av[2]), .b(bv[2]), .cin(ci[2]),
        .busy(bz[2]), .done(dn[2]), .sum(sum2), .co(cov[2]), .ovf(ovv[2])
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] get_sum(input int d);
        case (d)
            0:       return {5'b0, sum0};
            1:       return sum1;
            default: return sum2;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: start at the next edge, then check busy/done timing,
    // result hold during RUN, the completion values and the done fall.
    task automatic do_op(input int d, input string tag, input logic s,
                         input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [7:0] es, input logic eco, input logic eov,
                         input int ncyc);
        st[d] = 1'b1; sb[d] = s; av[d] = x; bv[d] = y; ci[d] = c;
        tick();
        // Inputs are free to change once sampled.
        st[d] = 1'b0; sb[d] = ~s; av[d] = 8'h5A; bv[d] = 8'hC3; ci[d] = ~c;
        for (int i = 0; i < ncyc; i++) begin
            check_eq($sformatf("%s busy[%0d]", tag, i), 8'(bz[d]), 8'd1);
            check_eq($sformatf("%s done_early[%0d]", tag, i), 8'(dn[d]), 8'd0);
            check_eq($sformatf("%s sum_hold[%0d]", tag, i), get_sum(d), prev[d]);
            tick();
        end
        check_eq({tag, " done"}, 8'(dn[d]), 8'd1);
        check_eq({tag, " busy_at_done"}, 8'(bz[d]), 8'd0);
        check_eq({tag, " sum"}, get_sum(d), es);
        check_eq({tag, " co"}, 8'(cov[d]), 8'(eco));
        check_eq({tag, " ovf"}, 8'(ovv[d]), 8'(eov));
        prev[d] = es;
        tick();
        check_eq({tag, " done_fall"}, 8'(dn[d]), 8'd0);
        check_eq({tag, " busy_after"}, 8'(bz[d]), 8'd0);
        check_eq({tag, " sum_held"}, get_sum(d), es);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b1;
        st = '0; sb = '0; ci = '0;
        for (int d = 0; d < 3; d++) begin
            av[d] = '0; bv[d] = '0; prev[d] = '0;
        end

        // Reset state
        #2;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst sum d%0d", d), get_sum(d), 8'h00);
            check_eq($sformatf("rst busy d%0d", d), 8'(bz[d]), 8'd0);
            check_eq($sformatf("rst done d%0d", d), 8'(dn[d]), 8'd0);
            check_eq($sformatf("rst co d%0d", d), 8'(cov[d]), 8'd0);
            check_eq($sformatf("rst ovf d%0d", d), 8'(ovv[d]), 8'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=3, CHUNK=1
        do_op(0, "w3_1p1", 1'b0, 8'h1, 8'h1, 1'b0, 8'h2, 1'b0, 1'b0, 3);
        do_op(0, "w3_3p2c", 1'b0, 8'h3, 8'h2, 1'b1, 8'h6, 1'b0, 1'b1, 3);
        do_op(0, "w3_3p4", 1'b0, 8'h3, 8'h4, 1'b0, 8'h7, 1'b0, 1'b0, 3);
        do_op(0, "w3_7p1", 1'b0, 8'h7, 8'h1, 1'b0, 8'h0, 1'b1, 1'b0, 3);

        // WIDTH=8, CHUNK=2 add
        do_op(1, "add_7f01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4);
        do_op(1, "add_ff01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 4);
        do_op(1, "add_55aa", 1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 4);

        // WIDTH=8, CHUNK=2 subtract
        do_op(1, "sub_0507", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 4);
        do_op(1, "sub_100f", 1'b1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 4);
        do_op(1, "sub_8001", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 4);

        // Start held high through RUN and DONE is ignored, not queued
        st[1] = 1'b1; sb[1] = 1'b0; av[1] = 8'h7F; bv[1] = 8'h01; ci[1] = 1'b0;
        tick();
        av[1] = 8'h01; bv[1] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("busy_ign hold[%0d]", i), sum1, 8'h7F);
            check_eq($sformatf("busy_ign busy[%0d]", i), 8'(bz[1]), 8'd1);
            tick();
        end
        check_eq("busy_ign done", 8'(dn[1]), 8'd1);
        check_eq("busy_ign sum", sum1, 8'h80);
        check_eq("busy_ign ovf", 8'(ovv[1]), 8'd1);
        tick();
        st[1] = 1'b0;
        check_eq("busy_ign done_fall", 8'(dn[1]), 8'd0);
        tick();
        check_eq("busy_ign no_requeue busy", 8'(bz[1]), 8'd0);
        check_eq("busy_ign no_requeue done", 8'(dn[1]), 8'd0);
        check_eq("busy_ign sum_kept", sum1, 8'h80);
        prev[1] = 8'h80;
        do_op(1, "after_done", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 4);

        // Asynchronous reset while slice 2 is being processed
        st[1] = 1'b1; sb[1] = 1'b0; av[1] = 8'h20; bv[1] = 8'h30; ci[1] = 1'b0;
        tick();
        st[1] = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst sum", sum1, 8'h00);
        check_eq("arst busy", 8'(bz[1]), 8'd0);
        check_eq("arst done", 8'(dn[1]), 8'd0);
        check_eq("arst co", 8'(cov[1]), 8'd0);
        check_eq("arst ovf", 8'(ovv[1]), 8'd0);
        check_eq("arst sum d0", get_sum(0), 8'h00);
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) prev[d] = '0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("arst no_done[%0d]", i), 8'(dn[1]), 8'd0);
            tick();
        end
        do_op(1, "post_rst", 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 4);

        // CHUNK=WIDTH: single RUN cycle
        do_op(2, "c8_ff00", 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
